pipe_ctrl: RTL

Central stall/bubble controller for the 5-stage miniMIPS pipeline.
- Detects load-use hazards between the decode stage's source registers and a load in EX.
- Honours the decode stage's stall request.
- Sequences the data-memory req/ack handshake for LW/SW in MEM.
- Drives one hold signal per pipeline register plus an EX bubble.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_det.sv | 29 ++
 rtl/pipe_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// =============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared constants for the miniMIPS pipeline stall controller:
//               ALU opcodes, stall bit indices and memory FSM encodings.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic [3:0] ALU_LW = 4'hA;
  localparam logic [3:0] ALU_SW = 4'hB;

  localparam int STALL_PC    = 0;
  localparam int STALL_IF_ID = 1;
  localparam int STALL_ID_EX = 2;
  localparam int STALL_EX_WB = 3;
  localparam int STALL_WB    = 4;

  localparam logic [4:0] STALL_ALL = 5'b11111;
  localparam logic [4:0] STALL_DEC = 5'b00011;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_DONE = 2'd2
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// =============================================================================
// Module      : pipe_ctrl_if
// Description : Pipeline-side signal bundle of the stall controller; master is
//               the controller, slave is the pipeline/memory side.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_stallreq;
  logic [4:0]       id_r1addr;
  logic [4:0]       id_r2addr;
  logic [3:0]       ex_aluop;
  logic             ex_wreg;
  logic [4:0]       ex_wraddr;
  logic             mem_valid;
  logic [3:0]       mem_aluop;
  logic             dmem_ack;
  logic             dmem_req;
  logic [4:0]       stall;
  logic             ex_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] ldu_cnt;

  modport master (
    input  id_stallreq, id_r1addr, id_r2addr,
    input  ex_aluop, ex_wreg, ex_wraddr,
    input  mem_valid, mem_aluop, dmem_ack,
    output dmem_req, stall, ex_bubble, mem_err, ldu_cnt
  );

  modport slave (
    output id_stallreq, id_r1addr, id_r2addr,
    output ex_aluop, ex_wreg, ex_wraddr,
    output mem_valid, mem_aluop, dmem_ack,
    input  dmem_req, stall, ex_bubble, mem_err, ldu_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_det.sv
// =============================================================================
// Module      : pipe_hazard_det
// Description : Combinational load-use comparator between a load in EX and the
//               decode-stage source registers. Register 0 never hazards.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module pipe_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  wire logic [3:0] i_ex_aluop,
  input  wire logic       i_ex_wreg,
  input  wire logic [4:0] i_ex_wraddr,
  input  wire logic [4:0] i_id_r1addr,
  input  wire logic [4:0] i_id_r2addr,
  output logic            o_hazard
);

  logic w_is_load;
  logic w_addr_match;

  assign w_is_load    = (i_ex_aluop == ALU_LW) && i_ex_wreg && (i_ex_wraddr != 5'd0);
  assign w_addr_match = (i_ex_wraddr == i_id_r1addr) || (i_ex_wraddr == i_id_r2addr);
  assign o_hazard     = w_is_load && w_addr_match;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// =============================================================================
// Module      : pipe_ctrl
// Description : Stall/bubble controller for the 5-stage miniMIPS pipeline:
//               memory handshake FSM, decode/load-use stall and perf counter.
//               Optional dmem timeout enabled by macro PIPE_CTRL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  wire logic   clk,
  input  wire logic   resetn,
  pipe_ctrl_if.master bus
);

  mem_state_t       r_state;
  mem_state_t       w_state_nxt;
  logic             r_dmem_req;
  logic             w_dmem_req_nxt;
  logic [CNT_W-1:0] r_ldu_cnt;
  logic             w_hazard;
  logic             w_mem_op;
  logic             w_mem_stall;
  logic             w_dec_stall;
  logic             w_cnt_en;
  logic [4:0]       w_stall;
  logic             w_ex_bubble;

  pipe_hazard_det u_hazard (
    .i_ex_aluop  (bus.ex_aluop),
    .i_ex_wreg   (bus.ex_wreg),
    .i_ex_wraddr (bus.ex_wraddr),
    .i_id_r1addr (bus.id_r1addr),
    .i_id_r2addr (bus.id_r2addr),
    .o_hazard    (w_hazard)
  );

  assign w_mem_op    = bus.mem_valid && ((bus.mem_aluop == ALU_LW) || (bus.mem_aluop == ALU_SW));
  assign w_dec_stall = bus.id_stallreq || w_hazard;

`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam int               c_WAIT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYC - 1);

  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_mem_err;
  logic                w_timeout;

  // An ack on the final wait cycle takes precedence over the timeout.
  assign w_timeout = (r_state == M_WAIT) && !bus.dmem_ack && (r_wait_cnt == c_WAIT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_mem_err <= w_timeout;
      if (r_state == M_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign bus.mem_err = r_mem_err;
`else
  assign bus.mem_err = 1'b0;
  if (TIMEOUT_CYC == 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= M_IDLE;
      r_dmem_req <= 1'b0;
      r_ldu_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_dmem_req <= w_dmem_req_nxt;
      if (w_cnt_en) begin
        r_ldu_cnt <= r_ldu_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_dmem_req_nxt = r_dmem_req;
    w_mem_stall    = 1'b0;
    case (r_state)
      M_IDLE: begin
        if (w_mem_op) begin
          w_mem_stall    = 1'b1;
          w_state_nxt    = M_WAIT;
          w_dmem_req_nxt = 1'b1;
        end
      end
      M_WAIT: begin
        w_mem_stall = 1'b1;
        if (bus.dmem_ack) begin
          w_state_nxt    = M_DONE;
          w_dmem_req_nxt = 1'b0;
        end
`ifdef PIPE_CTRL_TIMEOUT_EN
        else if (w_timeout) begin
          w_state_nxt    = M_DONE;
          w_dmem_req_nxt = 1'b0;
        end
`endif
      end
      // One unstalled cycle lets the memory instruction leave MEM.
      M_DONE: begin
        w_state_nxt = M_IDLE;
      end
      default: begin
        w_state_nxt    = M_IDLE;
        w_dmem_req_nxt = 1'b0;
      end
    endcase

    w_stall     = '0;
    w_ex_bubble = 1'b0;
    if (w_mem_stall) begin
      w_stall = STALL_ALL;
    end else if (w_dec_stall) begin
      w_stall     = STALL_DEC;
      w_ex_bubble = 1'b1;
    end
  end

  assign w_cnt_en      = w_hazard && !w_mem_stall && (r_ldu_cnt != {CNT_W{1'b1}});
  assign bus.dmem_req  = r_dmem_req;
  assign bus.stall     = w_stall;
  assign bus.ex_bubble = w_ex_bubble;
  assign bus.ldu_cnt   = r_ldu_cnt;

endmodule

`default_nettype wire
